// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge-pack custom instruction.
package sobel_pkg;

   typedef logic [7:0] pixel_t;

   localparam int GRAD_W = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0]        COMPUTE_ID_DEF = 8'd0;
   localparam logic [7:0]        RETURN_ID_DEF  = 8'd1;
   localparam logic [7:0]        CONFIG_ID_DEF  = 8'd2;
   localparam logic [GRAD_W-1:0] THRESHOLD_DEF  = 11'd127;

endpackage

// File: rtl/sobel_grad.sv
// Combinational 3x3 Sobel magnitude: |Gx| + |Gy| over eight neighbour pixels.
module sobel_grad
   import sobel_pkg::*;
(
   input  pixel_t              tl,
   input  pixel_t              tm,
   input  pixel_t              tr,
   input  pixel_t              ml,
   input  pixel_t              mr,
   input  pixel_t              bl,
   input  pixel_t              bm,
   input  pixel_t              br,
   output logic [GRAD_W-1:0]   mag
);

   function automatic logic signed [GRAD_W-1:0] ext(input pixel_t p);
      return $signed({3'b000, p});
   endfunction

   logic signed [GRAD_W-1:0] gx;
   logic signed [GRAD_W-1:0] gy;
   logic        [GRAD_W-1:0] ax;
   logic        [GRAD_W-1:0] ay;

   // Gradients span -1020..1020, so 11-bit signed holds them and the sum of magnitudes (max 2040) without loss.
   always_comb begin
      gx  = (ext(tr) - ext(tl)) + ((ext(mr) - ext(ml)) <<< 1) + (ext(br) - ext(bl));
      gy  = (ext(tl) - ext(bl)) + ((ext(tm) - ext(bm)) <<< 1) + (ext(tr) - ext(br));
      ax  = gx[GRAD_W-1] ? -gx : gx;
      ay  = gy[GRAD_W-1] ? -gy : gy;
      mag = ax + ay;
   end

endmodule

// File: rtl/sobel_pack_ci.sv
// Sobel edge detector custom instruction that packs thresholded edge bits into a word.
// Optional build macro SOBEL_STATUS_EN: CONFIG with valueB[0]=1 returns {overflow, count}
// instead of writing the threshold.
//
// state | meaning
// IDLE  | waiting for start; only state that accepts an instruction
// CALC  | compute operands held, magnitude settling through sobel_grad
// RESP  | done pulse with result; returns to IDLE
module sobel_pack_ci
   import sobel_pkg::*;
#(
   parameter logic [7:0]        COMPUTE_ID        = COMPUTE_ID_DEF,
   parameter logic [7:0]        RETURN_ID         = RETURN_ID_DEF,
   parameter logic [7:0]        CONFIG_ID         = CONFIG_ID_DEF,
   parameter logic [GRAD_W-1:0] THRESHOLD_DEFAULT = THRESHOLD_DEF,
   parameter int                PACK_BITS         = 32
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  iseId,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result
);

   localparam int         IDX_W = $clog2(PACK_BITS);
   localparam logic [5:0] FULL  = 6'(PACK_BITS);

   state_t               state;
   state_t               state_nx;
   logic [31:0]          op_a;
   logic [31:0]          op_b;
   logic [PACK_BITS-1:0] pack;
   logic [5:0]           count;
   logic [GRAD_W-1:0]    threshold;
   logic [GRAD_W-1:0]    mag;
   logic                 full;
   logic                 acc_compute;
   logic                 acc_return;
   logic                 acc_config;
   logic                 status_rd;

   assign full = (count == FULL);

`ifdef SOBEL_STATUS_EN
   logic overflow;
   assign status_rd = valueB[0];
`else
   assign status_rd = 1'b0;
`endif

   sobel_grad u_grad (
      .tl  (op_a[31:24]),
      .tm  (op_a[23:16]),
      .tr  (op_a[15:8]),
      .ml  (op_a[7:0]),
      .mr  (op_b[7:0]),
      .bl  (op_b[31:24]),
      .bm  (op_b[23:16]),
      .br  (op_b[15:8]),
      .mag (mag)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode; instructions are accepted only from IDLE.
   always_comb begin
      state_nx    = state;
      acc_compute = 1'b0;
      acc_return  = 1'b0;
      acc_config  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (iseId == COMPUTE_ID) begin
                  acc_compute = 1'b1;
                  state_nx    = CALC;
               end else if (iseId == RETURN_ID) begin
                  acc_return = 1'b1;
                  state_nx   = RESP;
               end else if (iseId == CONFIG_ID) begin
                  acc_config = 1'b1;
                  state_nx   = RESP;
               end
            end
         end
         CALC:    state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture for the compute path; contents are don't-care outside CALC.
   always_ff @(posedge clock) begin
      if (acc_compute) begin
         op_a <= valueA;
         op_b <= valueB;
      end
   end

   // Response register: done and a non-zero result exist only in the RESP cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         done   <= 1'b0;
         result <= 32'd0;
      end else begin
         done   <= 1'b0;
         result <= 32'd0;
         if (state == CALC) begin
            done   <= 1'b1;
            result <= 32'(mag);
         end else if (acc_return) begin
            done   <= 1'b1;
            result <= 32'(pack);
         end else if (acc_config) begin
            done   <= 1'b1;
`ifdef SOBEL_STATUS_EN
            result <= status_rd ? {overflow, 25'd0, count} : 32'(threshold);
`else
            result <= 32'(threshold);
`endif
         end
      end
   end

   // Packing and threshold; a bit computed while full is dropped.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pack      <= '0;
         count     <= 6'd0;
         threshold <= THRESHOLD_DEFAULT;
      end else if (state == CALC) begin
         if (!full) begin
            pack[count[IDX_W-1:0]] <= (mag > threshold);
            count                  <= count + 6'd1;
         end
      end else if (acc_return) begin
         pack  <= '0;
         count <= 6'd0;
      end else if (acc_config && !status_rd) begin
         threshold <= valueA[GRAD_W-1:0];
      end
   end

`ifdef SOBEL_STATUS_EN
   // Sticky overflow: set by a dropped bit, cleared only by a read-and-clear.
   always_ff @(posedge clock) begin
      if (!reset)                   overflow <= 1'b0;
      else if (state == CALC && full) overflow <= 1'b1;
      else if (acc_return)          overflow <= 1'b0;
   end
`endif

endmodule

// File: doc/sobel_pack_ci.md
SOBEL_PACK_CI -- requirements
Module: sobel_pack_ci

Interface
REQ-001 SHALL have parameter COMPUTE_ID, default 8'd0, iseId that selects the gradient-compute instruction.
REQ-002 SHALL have parameter RETURN_ID, default 8'd1, iseId that selects the read-and-clear of the packed word.
REQ-003 SHALL have parameter CONFIG_ID, default 8'd2, iseId that selects the threshold write.
REQ-004 SHALL have parameter THRESHOLD_DEFAULT, default 11'd127, threshold loaded at reset.
REQ-005 SHALL have parameter PACK_BITS, default 32, number of binary pixels packed per word; legal values are 8, 16 and 32.
REQ-006 SHALL have port clock, input, 1 bit, the single clock.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-low reset (0 = reset, sampled on the rising clock edge).
REQ-008 SHALL have ports start (input, 1), iseId (input, 8), valueA (input, 32) and valueB (input, 32), carrying the custom-instruction request.
REQ-009 SHALL have ports done (output, 1) and result (output, 32), carrying the custom-instruction response.

Function
REQ-010 SHALL use this pixel map: valueA[31:24]=TL, [23:16]=TM, [15:8]=TR, [7:0]=ML; valueB[31:24]=BL, [23:16]=BM, [15:8]=BR, [7:0]=MR; all pixels unsigned 8 bit.
REQ-011 SHALL compute Gx=(TR-TL)+2(MR-ML)+(BR-BL) and Gy=(TL-BL)+2(TM-BM)+(TR-BR) as 11-bit signed values, and mag=|Gx|+|Gy| as 11-bit unsigned (maximum 2040), with no truncation.
REQ-012 SHALL implement FSM states IDLE, CALC and RESP; start is accepted only in IDLE, and start in any other state is ignored.
REQ-013 SHALL, for COMPUTE_ID with start in cycle t: register the operands into CALC at t+1, assert done in RESP at t+2 with result={21'b0,mag}, then return to IDLE.
REQ-014 SHALL, on each compute, set bit = (mag > threshold) and write it into pack[count] (LSB first), then increment count.
REQ-015 SHALL, when count==PACK_BITS (full), drop the bit of any further compute, leave count unchanged and set the sticky overflow flag.
REQ-016 SHALL, for RETURN_ID, assert done at t+1 with result = pack zero-extended to 32 bits, and in the same edge clear pack, count and overflow.
REQ-017 SHALL, for CONFIG_ID, assert done at t+1 with result = {21'b0, old threshold} and load threshold from valueA[10:0].
REQ-018 SHALL, for any other iseId with start, leave done low and change no state.
REQ-019 SHALL hold done for exactly one cycle per accepted instruction.
REQ-020 SHALL drive result to 32'd0 whenever done is low.
REQ-021 SHALL, on RETURN_ID with count==0, return 0 and still assert done.

Reset
REQ-022 SHALL, while reset=0 at a clock edge, set state=IDLE, done=0, result=0, pack=0, count=0, overflow=0 and threshold=THRESHOLD_DEFAULT.
REQ-023 SHALL, when reset is asserted mid-operation (CALC or RESP), discard the in-flight instruction with no done pulse, and take no packing side effect from it.

Configuration
REQ-024 SHALL support macro SOBEL_STATUS_EN: when it is defined, a CONFIG_ID instruction with valueB[0]=1 does not write the threshold and returns {overflow, 25'b0, count[5:0]}.
REQ-025 SHALL, when SOBEL_STATUS_EN is undefined, ignore valueB for CONFIG_ID, synthesise no overflow register, and retain the REQ-015 drop behaviour.

Structure
REQ-026 SHALL place the following in package sobel_pkg: pixel typedef (8 bit), GRAD_W=11, the FSM state enum, and default ID constants.
REQ-027 SHALL contain one sub-module sobel_grad, taking 8 pixels and producing mag (combinational), instantiated between the operand register and RESP.

Verification
REQ-028 SHALL cover: all pixels 0x80, compute -> done exactly at t+2, result 0, packed bit 0.
REQ-029 SHALL cover: TL=ML=BL=0, TR=MR=BR=255, others 0 -> result 0x3FC (1020), packed bit 1.
REQ-030 SHALL cover: CONFIG with valueA=1100 -> result 127; then the REQ-029 edge -> result 1020, packed bit 0.
REQ-031 SHALL cover: PACK_BITS=32, 32 computes alternating edge/flat starting with edge, then RETURN -> 0x55555555; a second RETURN -> 0.
REQ-032 SHALL cover: with SOBEL_STATUS_EN, 33 edge computes, then CONFIG with valueB=1 -> 0x80000020, then RETURN -> 0xFFFFFFFF.
REQ-033 SHALL cover: reset=0 in the CALC cycle -> no done; after release, RETURN -> 0 and CONFIG status read -> threshold 127.
